// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bus bundle: master requests/transfer info in, grant info out.
// The "master" modport is the requester/bus side, "slave" is the arbiter side.
`timescale 1ns/1ps

interface ahb_arbiter_if;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter: round-robin grant, fixed-length burst hold,
// locked sequences, error abort and one-address-phase HMASTER/HMASTLOCK lag.
// Optional feature macro: AHB_ARB_TIMEOUT_EN -- caps undefined-length INCR
// bursts at TIMEOUT_BEATS beats so other requesters are not starved.
`timescale 1ns/1ps

module ahb_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned TIMEOUT_BEATS  = 16
) (
  input  logic          clk,
  input  logic          HRESETn,
  ahb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] TR_BUSY    = 2'b01;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] DEF_IDX    = DEFAULT_MASTER[1:0];
  localparam logic [3:0] DEF_GNT    = 4'b0001 << DEF_IDX;

  if (DEFAULT_MASTER > 3) begin : g_bad_default
    $error("DEFAULT_MASTER must be in 0..3");
  end
  if (TIMEOUT_BEATS < 2) begin : g_bad_timeout
    $error("TIMEOUT_BEATS must be at least 2");
  end

  // Round-robin search starting after ptr; bit 2 flags that a requester won.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, DEF_IDX};
    // Walk the search order backwards so the nearest requester overrides.
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + i[1:0];
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Remaining SEQ beats after the NONSEQ of a 4/8/16-beat burst.
  function automatic logic [3:0] beats_left(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  state_t     state_q;
  logic [3:0] grant_q;
  logic [1:0] gidx_q;
  logic [1:0] ptr_q;
  logic [3:0] cnt_q;
  logic [1:0] hmaster_q;
  logic       hmastlock_q;

  logic [2:0] arb;
  logic [1:0] arb_idx;
  logic       arb_found;
  logic       arb_lock;
  logic       cur_lock;
  logic       is_seq;
  logic       is_busy;
  logic       is_nonseq;
  logic       err;
  logic       burst_start;
  logic       keep;
  logic       tmo;
  logic       move;

  assign arb         = rr_pick(bus.HBUSREQ, ptr_q);
  assign arb_found   = arb[2];
  assign arb_idx     = arb[1:0];
  assign arb_lock    = arb_found && bus.HLOCK[arb_idx];
  assign cur_lock    = bus.HLOCK[gidx_q];
  assign is_seq      = (bus.HTRANS == TR_SEQ);
  assign is_busy     = (bus.HTRANS == TR_BUSY);
  assign is_nonseq   = (bus.HTRANS == TR_NONSEQ);
  assign err         = (bus.HRESP == RESP_ERROR);
  // Any NONSEQ with HBURST 010..111 starts a fixed-length burst.
  assign burst_start = is_nonseq && (bus.HBURST[2:1] != 2'b00);
  // The owner keeps the grant while it is inside an undefined-length burst.
  assign keep        = bus.HBUSREQ[gidx_q] &&
                       (is_seq || is_busy || (is_nonseq && bus.HBURST == 3'b001));

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_BEATS + 1);
  logic [HOLD_W-1:0] hold_q;
  assign tmo = is_seq && bus.HBUSREQ[gidx_q] &&
               (hold_q == HOLD_W'(TIMEOUT_BEATS - 1));
`else
  assign tmo = 1'b0;
`endif

  // Decide whether this HREADY edge hands the grant to the round-robin winner.
  always_comb begin
    move = 1'b0;
    if (err) begin
      move = 1'b1;
    end else begin
      case (state_q)
        FREE:    move = !cur_lock && !burst_start && !(keep && !tmo);
        BURST:   move = is_seq && (cnt_q <= 4'd1);
        LOCKED:  move = !cur_lock;
        default: move = 1'b1;
      endcase
    end
  end

  // Arbitration FSM with registered grant, owner index and lock outputs.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= FREE;
      grant_q     <= DEF_GNT;
      gidx_q      <= DEF_IDX;
      ptr_q       <= DEF_IDX;
      cnt_q       <= '0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else if (bus.HREADY) begin
      // Address phase follows the grant one HREADY edge later.
      hmaster_q   <= gidx_q;
      hmastlock_q <= cur_lock;

      if (move) begin
        grant_q <= 4'b0001 << arb_idx;
        gidx_q  <= arb_idx;
        if (arb_found) ptr_q <= arb_idx;
      end

      if (err) begin
        state_q <= FREE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          FREE: begin
            if (cur_lock) begin
              state_q <= LOCKED;
            end else if (burst_start) begin
              state_q <= BURST;
              cnt_q   <= beats_left(bus.HBURST[2:1]);
            end else if (move && arb_lock) begin
              state_q <= LOCKED;
            end
          end
          BURST: begin
            if (is_seq) begin
              if (cnt_q <= 4'd1) begin
                state_q <= FREE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q - 4'd1;
              end
            end
          end
          LOCKED: begin
            if (!cur_lock) state_q <= FREE;
          end
          default: begin
            state_q <= FREE;
            cnt_q   <= '0;
          end
        endcase
      end

`ifdef AHB_ARB_TIMEOUT_EN
      // Count beats of an undefined-length INCR held in FREE; the NONSEQ is beat 1.
      if (move || state_q != FREE || cur_lock || burst_start) begin
        hold_q <= '0;
      end else if (is_nonseq) begin
        hold_q <= HOLD_W'(1);
      end else if (is_seq) begin
        hold_q <= hold_q + 1'b1;
      end
`endif
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter: round-robin, default grant, fixed burst
// hold with BUSY/wait states, error abort, grant drop, lock, INCR timeout
// (AHB_ARB_TIMEOUT_EN aware) and asynchronous reset mid-burst.
`timescale 1ns/1ps

module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] ERR    = 2'b01;

  logic clk;
  logic HRESETn;
  int   n_assert;
  int   n_fail;

  ahb_arbiter_if bus();

  ahb_arbiter #(
    .DEFAULT_MASTER(0),
    .TIMEOUT_BEATS (16)
  ) dut (
    .clk    (clk),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input logic rdy, input logic [1:0] resp);
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = rdy;
    bus.HRESP   = resp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    HRESETn  = 1'b0;
    bus.HBUSREQ = 4'b0000;
    bus.HLOCK   = 4'b0000;
    bus.HTRANS  = IDLE;
    bus.HBURST  = 3'b000;
    bus.HREADY  = 1'b1;
    bus.HRESP   = OKAY;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", bus.HGRANT, 4'b0001);
    chk("reset_hmaster", {2'b00, bus.HMASTER}, 4'd0);
    chk("reset_hmastlock", {3'b000, bus.HMASTLOCK}, 4'd0);
    HRESETn = 1'b1;

    // Round-robin with all masters requesting SINGLE transfers.
    step(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1, OKAY);
    chk("rr1_grant", bus.HGRANT, 4'b0010);
    chk("rr1_hmaster", {2'b00, bus.HMASTER}, 4'd0);
    step(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1, OKAY);
    chk("rr2_grant", bus.HGRANT, 4'b0100);
    chk("rr2_hmaster", {2'b00, bus.HMASTER}, 4'd1);
    step(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1, OKAY);
    chk("rr3_grant", bus.HGRANT, 4'b1000);
    chk("rr3_hmaster", {2'b00, bus.HMASTER}, 4'd2);
    step(4'b1111, 4'b0000, NONSEQ, 3'b000, 1'b1, OKAY);
    chk("rr4_grant", bus.HGRANT, 4'b0001);
    chk("rr4_hmaster", {2'b00, bus.HMASTER}, 4'd3);

    // M1 runs INCR4 while M2 requests; BUSY and a wait state inside.
    step(4'b0110, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("b4_arb", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, NONSEQ, 3'b011, 1'b1, OKAY);
    chk("b4_nonseq", bus.HGRANT, 4'b0010);
    chk("b4_hmaster", {2'b00, bus.HMASTER}, 4'd1);
    step(4'b0110, 4'b0000, SEQ, 3'b011, 1'b1, OKAY);
    chk("b4_seq1", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, BUSY, 3'b011, 1'b1, OKAY);
    chk("b4_busy", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, SEQ, 3'b011, 1'b0, OKAY);
    chk("b4_wait", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, SEQ, 3'b011, 1'b1, OKAY);
    chk("b4_seq2", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, SEQ, 3'b011, 1'b1, OKAY);
    chk("b4_last", bus.HGRANT, 4'b0100);

    // No requests: grant falls back to the default master.
    step(4'b0000, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("dflt_grant", bus.HGRANT, 4'b0001);
    chk("dflt_hmaster", {2'b00, bus.HMASTER}, 4'd2);

    // M3 WRAP8 with wait states, then a two-cycle ERROR on beat 2.
    step(4'b1010, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("w8_arb", bus.HGRANT, 4'b1000);
    step(4'b1010, 4'b0000, NONSEQ, 3'b100, 1'b1, OKAY);
    chk("w8_nonseq", bus.HGRANT, 4'b1000);
    step(4'b1010, 4'b0000, SEQ, 3'b100, 1'b0, OKAY);
    chk("w8_wait1", bus.HGRANT, 4'b1000);
    step(4'b1010, 4'b0000, SEQ, 3'b100, 1'b0, OKAY);
    chk("w8_wait2", bus.HGRANT, 4'b1000);
    step(4'b1010, 4'b0000, SEQ, 3'b100, 1'b0, ERR);
    chk("w8_wait_err", bus.HGRANT, 4'b1000);
    chk("w8_wait_hmaster", {2'b00, bus.HMASTER}, 4'd3);
    step(4'b1010, 4'b0000, SEQ, 3'b100, 1'b1, ERR);
    chk("w8_error", bus.HGRANT, 4'b0010);

    // M1 in INCR keeps the grant until it drops its request.
    step(4'b0110, 4'b0000, NONSEQ, 3'b001, 1'b1, OKAY);
    chk("drop_nonseq", bus.HGRANT, 4'b0010);
    step(4'b0110, 4'b0000, SEQ, 3'b001, 1'b1, OKAY);
    chk("drop_seq", bus.HGRANT, 4'b0010);
    step(4'b0100, 4'b0000, SEQ, 3'b001, 1'b1, OKAY);
    chk("drop_lost", bus.HGRANT, 4'b0100);

    // M3 locked over six SINGLE transfers while M0 requests.
    step(4'b1001, 4'b1000, IDLE, 3'b000, 1'b1, OKAY);
    chk("lk_enter_grant", bus.HGRANT, 4'b1000);
    chk("lk_enter_mlock", {3'b000, bus.HMASTLOCK}, 4'd0);
    for (int k = 0; k < 6; k++) begin
      step(4'b1001, 4'b1000, NONSEQ, 3'b000, 1'b1, OKAY);
      chk($sformatf("lk_hold%0d_grant", k), bus.HGRANT, 4'b1000);
      chk($sformatf("lk_hold%0d_mlock", k), {3'b000, bus.HMASTLOCK}, 4'd1);
    end
    step(4'b1001, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("lk_release_grant", bus.HGRANT, 4'b0001);
    chk("lk_release_mlock", {3'b000, bus.HMASTLOCK}, 4'd0);

    // M0 runs a 20-beat INCR while M1 requests.
    for (int b = 1; b <= 20; b++) begin
      step(4'b0011, 4'b0000, (b == 1) ? NONSEQ : SEQ, 3'b001, 1'b1, OKAY);
`ifdef AHB_ARB_TIMEOUT_EN
      chk($sformatf("incr_beat%0d", b), bus.HGRANT, (b < 16) ? 4'b0001 : 4'b0010);
      if (b == 16) break;
`else
      chk($sformatf("incr_beat%0d", b), bus.HGRANT, 4'b0001);
`endif
    end

    // M2 starts INCR8; reset lands mid-burst.
    step(4'b0100, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("b8_arb", bus.HGRANT, 4'b0100);
    step(4'b0100, 4'b0000, NONSEQ, 3'b101, 1'b1, OKAY);
    step(4'b0100, 4'b0000, SEQ, 3'b101, 1'b1, OKAY);
    chk("b8_mid_grant", bus.HGRANT, 4'b0100);
    chk("b8_mid_hmaster", {2'b00, bus.HMASTER}, 4'd2);
    @(negedge clk);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_grant", bus.HGRANT, 4'b0001);
    chk("async_rst_hmaster", {2'b00, bus.HMASTER}, 4'd0);
    chk("async_rst_mlock", {3'b000, bus.HMASTLOCK}, 4'd0);
    #1;
    HRESETn = 1'b1;
    step(4'b1100, 4'b0000, IDLE, 3'b000, 1'b1, OKAY);
    chk("post_rst_rr", bus.HGRANT, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
